// File: rtl/rrf_if.sv
// rrf_if: commit/free/query bus of the retirement register file.
//   slave  modport : the RRF itself
//   master modport : environment (ROB head, free list, recovery/debug query)
//   rob_*  : ROB commit handshake (valid/ready, rd arch + new phys)
//   fl_*   : freed phys reg handshake toward the free list
//   q_*    : combinational committed-map query
//   commit_cnt : accepted commits since reset
interface rrf_if #(
  parameter int ARF_DEPTH = 32,
  parameter int PRF_DEPTH = 64
);
  localparam int ARF_IDX = $clog2(ARF_DEPTH);
  localparam int PRF_IDX = $clog2(PRF_DEPTH);

  logic               rob_valid;
  logic [PRF_IDX-1:0] rob_rd_phy;
  logic [ARF_IDX-1:0] rob_rd_arch;
  logic               rob_ready;
  logic               fl_valid;
  logic [PRF_IDX-1:0] fl_phy;
  logic               fl_ready;
  logic [ARF_IDX-1:0] q_arch;
  logic [PRF_IDX-1:0] q_phy;
  logic [31:0]        commit_cnt;

  modport slave (
    input  rob_valid, rob_rd_phy, rob_rd_arch, fl_ready, q_arch,
    output rob_ready, fl_valid, fl_phy, q_phy, commit_cnt
  );

  modport master (
    output rob_valid, rob_rd_phy, rob_rd_arch, fl_ready, q_arch,
    input  rob_ready, fl_valid, fl_phy, q_phy, commit_cnt
  );
endinterface

// File: rtl/rrf.sv
// rrf: retirement register file. Holds the committed arch->phys map,
// updated by the ROB head on each accepted commit. The phys reg that a
// commit supersedes is queued in a small FIFO and handed to the free list.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-low reset
//   bus  - rrf_if.slave: rob_* commit handshake, fl_* free handshake,
//          q_arch/q_phy map query, commit_cnt
// Optional feature: define RRF_FREE_BYPASS_EN to let a freed phys reg go
// straight to the free list in the commit cycle when the FIFO is empty.
module rrf #(
  parameter int ARF_DEPTH  = 32,
  parameter int PRF_DEPTH  = 64,
  parameter int FREE_DEPTH = 8
) (
  input logic   clk,
  input logic   rst,
  rrf_if.slave  bus
);
  localparam int ARF_IDX = $clog2(ARF_DEPTH);
  localparam int PRF_IDX = $clog2(PRF_DEPTH);
  localparam int FAW     = $clog2(FREE_DEPTH);
  localparam int PTR_W   = FAW + 1;

  logic [PRF_IDX-1:0] map  [ARF_DEPTH];
  logic [PRF_IDX-1:0] fifo [FREE_DEPTH];
  logic [PTR_W-1:0]   wp, rp;
  logic [31:0]        cnt;

  logic               full, empty, commit, wr_map, push, pop;
  logic [PRF_IDX-1:0] old_phy;

  // Pointers carry a wrap flag in the MSB so full/empty need no counter.
  assign full  = (wp[FAW-1:0] == rp[FAW-1:0]) && (wp[FAW] != rp[FAW]);
  assign empty = (wp == rp);

  // Ready looks only at the FIFO state, so a pop during full only frees
  // a slot for the following cycle.
  assign bus.rob_ready  = ~full;
  assign commit         = bus.rob_valid & ~full;
  // Arch 0 is hardwired to phys 0: no map write, nothing ever freed.
  assign wr_map         = commit & (bus.rob_rd_arch != '0);
  assign old_phy        = map[bus.rob_rd_arch];

  assign bus.q_phy      = map[bus.q_arch];
  assign bus.commit_cnt = cnt;

`ifdef RRF_FREE_BYPASS_EN
  logic byp;
  // Empty FIFO: offer the superseded phys reg in the same cycle; it is only
  // queued if the free list does not take it right away.
  assign byp          = wr_map & empty;
  assign bus.fl_valid = ~empty | byp;
  assign bus.fl_phy   = ~empty ? fifo[rp[FAW-1:0]] : (byp ? old_phy : '0);
  assign pop          = ~empty & bus.fl_ready;
  assign push         = wr_map & ~(byp & bus.fl_ready);
`else
  assign bus.fl_valid = ~empty;
  assign bus.fl_phy   = empty ? '0 : fifo[rp[FAW-1:0]];
  assign pop          = ~empty & bus.fl_ready;
  assign push         = wr_map;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ARF_DEPTH; i++) map[i] <= PRF_IDX'(i);
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_map) map[bus.rob_rd_arch] <= bus.rob_rd_phy;
      if (push)   wp  <= wp + 1'b1;
      if (pop)    rp  <= rp + 1'b1;
      if (commit) cnt <= cnt + 32'd1;
    end
  end

  // FIFO storage needs no reset: fl_phy is masked while empty.
  always_ff @(posedge clk) begin
    if (push) fifo[wp[FAW-1:0]] <= old_phy;
  end

  // Unused-width guard: ARF_IDX is only used through the interface widths.
  localparam int ARF_IDX_CHK = ARF_IDX;
endmodule

// File: tb/tb_rrf.sv
module tb_rrf;
  logic clk, rst;
  int n_chk, n_fail;

  rrf_if #(.ARF_DEPTH(32), .PRF_DEPTH(64)) bus ();
  rrf #(.ARF_DEPTH(32), .PRF_DEPTH(64), .FREE_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int v, arch, phy, flr, q;
    int e_rr, e_flv, e_flphy, e_q, e_cnt;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int v, input int arch, input int phy, input int flr, input int q);
    bus.rob_valid   = (v != 0);
    bus.rob_rd_arch = 5'(arch);
    bus.rob_rd_phy  = 6'(phy);
    bus.fl_ready    = (flr != 0);
    bus.q_arch      = 5'(q);
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    rst = 1'b0;
    drive(0, 0, 0, 0, 7);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_phy",     32'(bus.q_phy), 7);
    chk("rst_fl_valid",  32'(bus.fl_valid), 0);
    chk("rst_fl_phy",    32'(bus.fl_phy), 0);
    chk("rst_rob_ready", 32'(bus.rob_ready), 1);
    chk("rst_cnt",       32'(bus.commit_cnt), 0);
    rst = 1'b1;

    // Expected values are the outputs seen before the edge that applies the inputs.
    //           v arch phy flr q   rr flv flphy q_phy cnt
    tbl[0] = '{1, 5, 40, 1, 5,  1, 0, 0,  5,  0};
    tbl[1] = '{1, 0, 33, 1, 5,  1, 1, 5,  40, 1};
    tbl[2] = '{0, 0, 0,  1, 0,  1, 0, 0,  0,  2};
    tbl[3] = '{1, 3, 50, 0, 3,  1, 0, 0,  3,  2};
    tbl[4] = '{1, 3, 51, 0, 3,  1, 1, 3,  50, 3};
    tbl[5] = '{0, 0, 0,  1, 3,  1, 1, 3,  51, 4};
    tbl[6] = '{0, 0, 0,  1, 3,  1, 1, 50, 51, 4};
    tbl[7] = '{0, 0, 0,  0, 0,  1, 0, 0,  0,  4};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].v, tbl[i].arch, tbl[i].phy, tbl[i].flr, tbl[i].q);
      @(negedge clk);
      chk($sformatf("v%0d_rob_ready", i), 32'(bus.rob_ready), tbl[i].e_rr);
      chk($sformatf("v%0d_fl_valid", i),  32'(bus.fl_valid), tbl[i].e_flv);
      chk($sformatf("v%0d_fl_phy", i),    32'(bus.fl_phy), tbl[i].e_flphy);
      chk($sformatf("v%0d_q_phy", i),     32'(bus.q_phy), tbl[i].e_q);
      chk($sformatf("v%0d_cnt", i),       32'(bus.commit_cnt), tbl[i].e_cnt);
      next_cycle();
    end

    // Fill the FIFO with the free list stalled.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1, k + 1, 40 + k, 0, 0);
      @(negedge clk);
      chk($sformatf("fill%0d_rob_ready", k), 32'(bus.rob_ready), 1);
      chk($sformatf("fill%0d_fl_valid", k), 32'(bus.fl_valid), (k > 0) ? 1 : 0);
      next_cycle();
    end
    // Commit offered while full must be refused.
    drive(1, 9, 48, 0, 8);
    @(negedge clk);
    chk("full_rob_ready", 32'(bus.rob_ready), 0);
    chk("full_fl_valid",  32'(bus.fl_valid), 1);
    chk("full_fl_phy",    32'(bus.fl_phy), 1);
    chk("full_cnt",       32'(bus.commit_cnt), 8);
    chk("full_q_phy",     32'(bus.q_phy), 47);
    next_cycle();
    drive(0, 0, 0, 1, 9);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk($sformatf("drain%0d_fl_valid", j), 32'(bus.fl_valid), 1);
      chk($sformatf("drain%0d_fl_phy", j), 32'(bus.fl_phy), j + 1);
      chk($sformatf("drain%0d_rob_ready", j), 32'(bus.rob_ready), (j == 0) ? 0 : 1);
      next_cycle();
    end
    @(negedge clk);
    chk("drained_fl_valid", 32'(bus.fl_valid), 0);
    chk("drained_cnt",      32'(bus.commit_cnt), 8);
    chk("refused_q_phy",    32'(bus.q_phy), 9);
    next_cycle();

    // Push and pop in the same cycle keep occupancy at one.
    drive(1, 9, 48, 1, 9);
    @(negedge clk);
    chk("pp0_fl_valid", 32'(bus.fl_valid), 0);
    next_cycle();
    drive(1, 10, 49, 1, 9);
    @(negedge clk);
    chk("pp1_fl_valid", 32'(bus.fl_valid), 1);
    chk("pp1_fl_phy",   32'(bus.fl_phy), 9);
    chk("pp1_q_phy",    32'(bus.q_phy), 48);
    next_cycle();
    drive(0, 0, 0, 0, 10);
    @(negedge clk);
    chk("pp2_fl_valid", 32'(bus.fl_valid), 1);
    chk("pp2_fl_phy",   32'(bus.fl_phy), 10);
    chk("pp2_q_phy",    32'(bus.q_phy), 49);
    chk("pp2_cnt",      32'(bus.commit_cnt), 10);
    next_cycle();
    @(negedge clk);
    chk("pp3_fl_phy_hold", 32'(bus.fl_phy), 10);
    next_cycle();
    drive(0, 0, 0, 1, 10);
    next_cycle();
    @(negedge clk);
    chk("pp4_fl_valid", 32'(bus.fl_valid), 0);
    next_cycle();

    // Asynchronous reset with three entries pending.
    for (int k = 0; k < 3; k++) begin
      drive(1, k + 1, 52 + k, 0, 3);
      next_cycle();
    end
    drive(0, 0, 0, 0, 3);
    @(negedge clk);
    chk("pre_rst_fl_valid", 32'(bus.fl_valid), 1);
    chk("pre_rst_q_phy",    32'(bus.q_phy), 54);
    #1 rst = 1'b0;
    #1;
    chk("async_fl_valid",  32'(bus.fl_valid), 0);
    chk("async_rob_ready", 32'(bus.rob_ready), 1);
    chk("async_cnt",       32'(bus.commit_cnt), 0);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_q_phy",    32'(bus.q_phy), 3);
    chk("post_rst_fl_valid", 32'(bus.fl_valid), 0);
    chk("post_rst_cnt",      32'(bus.commit_cnt), 0);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
